mastermind_solver: RTL and testbench

MASTERMIND_SOLVER -- requirements
Module: mastermind_solver

---
 rtl/mastermind_solver.sv | 151 +++++++++++++++
 tb/tb_mastermind_solver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mastermind_solver.sv
// rtl/mastermind_solver.sv - 4-digit, 4-colour Mastermind code breaker
// Proposes the lowest code consistent with every feedback received so far.
module mastermind_solver #(
  parameter int MAX_GUESSES = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       guessValid,
  output logic [1:0] guess3,
  output logic [1:0] guess2,
  output logic [1:0] guess1,
  output logic [1:0] guess0,
  input  logic       fbValid,
  input  logic [3:0] fbCorrect,
  input  logic [3:0] fbValue,
  output logic       busy,
  output logic       solved,
  output logic       failed,
  output logic [3:0] guessCount
);

  typedef enum logic [2:0] {IDLE, PROPOSE, SEARCH, SOLVED, FAILED} state_t;

  state_t     state_q, state_d;
  logic [7:0] cand_q, cand_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       guess_valid_q, guess_valid_d;
  logic       busy_q, busy_d;
  logic       solved_q, solved_d;
  logic       failed_q, failed_d;
  logic       hist_we;
  logic [7:0] sc;

  logic [7:0] hist_guess_q [MAX_GUESSES];
  logic [3:0] hist_cl_q    [MAX_GUESSES];
  logic [3:0] hist_vo_q    [MAX_GUESSES];

  // Returns {right place, right colour wrong place} for code a against code b.
  function automatic logic [7:0] score(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] cl, tot, ca, cb;
    cl  = 4'd0;
    tot = 4'd0;
    for (int p = 0; p < 4; p++)
      if (a[2*p +: 2] == b[2*p +: 2]) cl = cl + 4'd1;
    for (int c = 0; c < 4; c++) begin
      ca = 4'd0;
      cb = 4'd0;
      for (int p = 0; p < 4; p++) begin
        if (a[2*p +: 2] == 2'(c)) ca = ca + 4'd1;
        if (b[2*p +: 2] == 2'(c)) cb = cb + 4'd1;
      end
      tot = tot + ((ca < cb) ? ca : cb);
    end
    return {cl, tot - cl};
  endfunction

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    hist_we = 1'b0;
    sc      = score(cand_q, hist_guess_q[idx_q]);
    case (state_q)
      IDLE, SOLVED, FAILED: begin
        if (start) begin
          state_d = PROPOSE;
          cand_d  = 8'd0;
          idx_d   = 4'd0;
          cnt_d   = 4'd0;
        end
      end
      PROPOSE: begin
        if (fbValid) begin
          hist_we = 1'b1;
          cnt_d   = cnt_q + 4'd1;
          if (fbCorrect == 4'd4) begin
            state_d = SOLVED;
          end else if (cnt_d == 4'(MAX_GUESSES)) begin
            state_d = FAILED;
          end else begin
            state_d = SEARCH;
            cand_d  = cand_q + 8'd1;
            idx_d   = 4'd0;
          end
        end
      end
      SEARCH: begin
        if (sc != {hist_cl_q[idx_q], hist_vo_q[idx_q]}) begin
          // Exhausting the code space means the feedback was inconsistent.
          if (cand_q == 8'hFF) begin
            state_d = FAILED;
          end else begin
            cand_d = cand_q + 8'd1;
            idx_d  = 4'd0;
          end
        end else if (idx_q == cnt_q - 4'd1) begin
          state_d = PROPOSE;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    guess_valid_d = (state_d == PROPOSE);
    busy_d        = (state_d == PROPOSE) || (state_d == SEARCH);
    solved_d      = (state_d == SOLVED);
    failed_d      = (state_d == FAILED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cand_q        <= 8'd0;
      idx_q         <= 4'd0;
      cnt_q         <= 4'd0;
      guess_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      solved_q      <= 1'b0;
      failed_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      guess_valid_q <= guess_valid_d;
      busy_q        <= busy_d;
      solved_q      <= solved_d;
      failed_q      <= failed_d;
    end
  end

  // Entries beyond guessCount are never read, so clearing the count invalidates them.
  always_ff @(posedge clk) begin
    if (!reset && hist_we) begin
      hist_guess_q[cnt_q] <= cand_q;
      hist_cl_q[cnt_q]    <= fbCorrect;
      hist_vo_q[cnt_q]    <= fbValue;
    end
  end

  assign guessValid = guess_valid_q;
  assign {guess3, guess2, guess1, guess0} = cand_q;
  assign busy       = busy_q;
  assign solved     = solved_q;
  assign failed     = failed_q;
  assign guessCount = cnt_q;

endmodule

// File: tb/tb_mastermind_solver.sv
// tb/tb_mastermind_solver.sv - scoreboard bench for mastermind_solver
module tb_mastermind_solver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, fbValid;
  logic [3:0] fbCorrect, fbValue;
  logic       guessValid, busy, solved, failed;
  logic [1:0] guess3, guess2, guess1, guess0;
  logic [3:0] guessCount;

  logic       start2, fbValid2;
  logic [3:0] fbCorrect2, fbValue2;
  logic       guessValid2, busy2, solved2, failed2;
  logic [1:0] g2_3, g2_2, g2_1, g2_0;
  logic [3:0] guessCount2;

  mastermind_solver #(.MAX_GUESSES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .guessValid(guessValid),
    .guess3(guess3), .guess2(guess2), .guess1(guess1), .guess0(guess0),
    .fbValid(fbValid), .fbCorrect(fbCorrect), .fbValue(fbValue),
    .busy(busy), .solved(solved), .failed(failed), .guessCount(guessCount)
  );

  mastermind_solver #(.MAX_GUESSES(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .guessValid(guessValid2),
    .guess3(g2_3), .guess2(g2_2), .guess1(g2_1), .guess0(g2_0),
    .fbValid(fbValid2), .fbCorrect(fbCorrect2), .fbValue(fbValue2),
    .busy(busy2), .solved(solved2), .failed(failed2), .guessCount(guessCount2)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       is_done;
    logic [7:0] guess;
    logic       sol;
    logic       fai;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic exp_guess(input logic [7:0] g);
    exp_t e;
    e = '0;
    e.guess = g;
    sb_q.push_back(e);
  endtask

  task automatic exp_done(input logic s, input logic f, input logic [3:0] c);
    exp_t e;
    e = '0;
    e.is_done = 1'b1;
    e.sol = s;
    e.fai = f;
    e.cnt = c;
    sb_q.push_back(e);
  endtask

  logic prev_gv   = 1'b0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (guessValid && !prev_gv) begin
      if (sb_q.size() == 0) chk("unexpected_guess", 1, 0);
      else begin
        e = sb_q.pop_front();
        chk("event_kind_guess", int'(e.is_done), 0);
        chk("guess_value", int'({guess3, guess2, guess1, guess0}), int'(e.guess));
      end
    end
    if ((solved || failed) && !prev_done) begin
      if (sb_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb_q.pop_front();
        chk("event_kind_done", int'(e.is_done), 1);
        chk("done_status", int'({solved, failed, guessCount}), int'({e.sol, e.fai, e.cnt}));
      end
    end
    prev_gv   = guessValid;
    prev_done = solved || failed;
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic give_fb(input logic [3:0] c, input logic [3:0] v);
    int n;
    n = 0;
    @(negedge clk);
    while (!guessValid && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!guessValid) chk("guess_timeout", 0, 1);
    fbCorrect = c;
    fbValue   = v;
    fbValid   = 1'b1;
    @(posedge clk);
    #1 fbValid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!(solved || failed) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!(solved || failed)) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int n;
    int gv_rises;
    logic pg;
    reset = 1'b1; start = 1'b0; fbValid = 1'b0; fbCorrect = '0; fbValue = '0;
    start2 = 1'b0; fbValid2 = 1'b0; fbCorrect2 = '0; fbValue2 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_guessValid", int'(guessValid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_solved", int'(solved), 0);
    chk("rst_failed", int'(failed), 0);
    chk("rst_guessCount", int'(guessCount), 0);
    chk("rst_guess", int'({guess3, guess2, guess1, guess0}), 0);

    // Secret 0000
    exp_guess(8'h00);
    exp_done(1'b1, 1'b0, 4'd1);
    pulse_start();
    @(negedge clk);
    chk("t1_guessValid", int'(guessValid), 1);
    chk("t1_guess", int'({guess3, guess2, guess1, guess0}), 0);
    give_fb(4'd4, 4'd0);
    @(negedge clk);
    chk("s0000_busy", int'(busy), 0);
    chk("s0000_solved", int'(solved), 1);

    // Secret 0001, restarted from SOLVED
    exp_guess(8'h00);
    exp_guess(8'h01);
    exp_done(1'b1, 1'b0, 4'd2);
    pulse_start();
    @(negedge clk);
    chk("restart_guessCount", int'(guessCount), 0);
    chk("restart_guess", int'({guess3, guess2, guess1, guess0}), 0);
    give_fb(4'd3, 4'd0);
    @(negedge clk);
    chk("s0001_search_gv", int'(guessValid), 0);
    @(negedge clk);
    chk("s0001_repropose", int'(guessValid), 1);
    give_fb(4'd4, 4'd0);
    wait_done();

    // Always (0,0): walks to a cand wrap
    exp_guess(8'h00);
    exp_guess(8'h55);
    exp_guess(8'hAA);
    exp_guess(8'hFF);
    exp_done(1'b0, 1'b1, 4'd4);
    pulse_start();
    give_fb(4'd0, 4'd0);
    fbCorrect = 4'd4; fbValid = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 begin fbValid = 1'b0; start = 1'b0; end
    @(negedge clk);
    chk("search_fb_ignored_cnt", int'(guessCount), 1);
    chk("search_start_ignored_busy", int'(busy), 1);
    chk("search_not_solved", int'(solved), 0);
    give_fb(4'd0, 4'd0);
    give_fb(4'd0, 4'd0);
    give_fb(4'd0, 4'd0);
    wait_done();
    chk("wrap_cand", int'({guess3, guess2, guess1, guess0}), 255);

    // Reset mid-SEARCH, with start and fbValid asserted alongside
    exp_guess(8'h00);
    pulse_start();
    give_fb(4'd0, 4'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1; start = 1'b1; fbValid = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_outputs", int'({guessValid, busy, solved, failed, guessCount, guess3, guess2, guess1, guess0}), 0);
    reset = 1'b0; start = 1'b0; fbValid = 1'b0;
    @(negedge clk);
    chk("midrst_start_blocked", int'(busy), 0);

    // MAX_GUESSES=2, secret 3333
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      @(negedge clk);
      while (!guessValid2 && n < 5000) begin @(negedge clk); n++; end
      chk("m2_guess", int'({g2_3, g2_2, g2_1, g2_0}), (k == 0) ? 0 : 8'h55);
      fbCorrect2 = 4'd0; fbValue2 = 4'd0; fbValid2 = 1'b1;
      @(posedge clk);
      #1 fbValid2 = 1'b0;
    end
    gv_rises = 0;
    pg = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (guessValid2 && !pg) gv_rises++;
      pg = guessValid2;
    end
    chk("m2_failed", int'(failed2), 1);
    chk("m2_guessCount", int'(guessCount2), 2);
    chk("m2_no_third_guess", gv_rises, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
